// File: rtl/ps2_dev_pkg.sv
// ps2_dev_pkg: shared types and constants for the PS/2 device transmitter.
//   state_t      FSM encoding (IDLE, SEND_HI, SEND_LO, GAP)
//   FRAME_BITS   bits per PS/2 frame (start + 8 data + parity + stop)
//   PS2_START / PS2_STOP  framing bit levels
//   build_frame  packs a byte into an 11-bit frame, bit 0 sent first
package ps2_dev_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic PS2_START  = 1'b0;
  localparam logic PS2_STOP   = 1'b1;

  // Odd parity: parity bit set when the data holds an even number of ones.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {PS2_STOP, ~^data, data, PS2_START};
  endfunction

endpackage

// File: rtl/ps2_dev_fifo.sv
// ps2_dev_fifo: small synchronous FIFO holding queued scancode bytes.
//   clk, srst        clock and synchronous active-high reset
//   wr_en, wr_data   push request and data (ignored while full)
//   rd_en            pop request (ignored while empty)
//   rd_data          head of the queue, valid whenever !empty
//   full, empty      status flags
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs. The head is read combinationally so the transmitter
// can latch it in the same cycle it sees the FIFO become non-empty.
module ps2_dev_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx: PS/2 device-to-host transmitter with a byte queue.
//   clk_i, rst_i    system clock, synchronous active-high reset
//   tx_data_i       byte to queue; accepted when tx_valid_i && tx_ready_o
//   tx_valid_i      push request
//   tx_ready_o      queue not full
//   ps2_clk_i       sensed PS/2 clock line (host may hold it low to inhibit)
//   ps2_clk_o       clock drive, 0 = pull low, 1 = release
//   ps2_dat_o       data drive, 0 = pull low, 1 = release
//   busy_o          FSM active or bytes queued
//   done_o          one-cycle pulse after a frame completes
//   abort_o         one-cycle pulse when the host inhibits mid-frame
// Each bit is a released half-period (data changes on its first cycle)
// followed by a pulled-low half-period. The inhibit check looks at the
// synchronized clock on the last released cycle, so CLK_DIV must be at
// least 3 for the echo of our own low phase to have cleared the synchronizer.
module ps2_dev_tx
  import ps2_dev_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_HP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       abort_o
);

  localparam int              CW       = $clog2(CLK_DIV * GAP_HP + 1);
  localparam logic [CW-1:0]   HP_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   GAP_LAST = CW'(CLK_DIV * GAP_HP - 1);
  localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [3:0]              bit_reg, bit_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic                    done_reg, done_next;
  logic                    abort_reg, abort_next;
  logic                    clk_meta_reg;
  logic                    clk_s_reg;

  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [7:0]              fifo_head;

  ps2_dev_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .srst    (rst_i),
    .wr_en   (tx_valid_i),
    .wr_data (tx_data_i),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_reg <= 1'b1;
      clk_s_reg    <= 1'b1;
    end else begin
      clk_meta_reg <= ps2_clk_i;
      clk_s_reg    <= clk_meta_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '1;
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      done_reg  <= done_next;
      abort_reg <= abort_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
    abort_next = 1'b0;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && clk_s_reg) begin
          state_next = SEND_HI;
          cnt_next   = '0;
          bit_next   = '0;
          shift_next = build_frame(fifo_head);
        end
      end
      SEND_HI: begin
        if (cnt_reg == HP_LAST) begin
          cnt_next = '0;
          if (!clk_s_reg) begin
            // Host inhibit: head stays queued and is resent from the start.
            abort_next = 1'b1;
            state_next = GAP;
          end else begin
            state_next = SEND_LO;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SEND_LO: begin
        if (cnt_reg == HP_LAST) begin
          cnt_next = '0;
          if (bit_reg == BIT_LAST) begin
            fifo_pop   = 1'b1;
            done_next  = 1'b1;
            state_next = GAP;
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = {PS2_STOP, shift_reg[FRAME_BITS-1:1]};
            state_next = SEND_HI;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ps2_clk_o  = (state_reg != SEND_LO);
  assign ps2_dat_o  = ((state_reg == SEND_HI) || (state_reg == SEND_LO)) ? shift_reg[0] : 1'b1;
  assign busy_o     = (state_reg != IDLE) || !fifo_empty;
  assign done_o     = done_reg;
  assign abort_o    = abort_reg;
  assign tx_ready_o = !fifo_full;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed testbench for ps2_dev_tx with CLK_DIV=4, GAP_HP=4, FIFO_DEPTH=4.
// The PS/2 clock line is modelled as a wired-AND of the device drive and
// a host drive.
module tb_ps2_dev_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_HP     = 4;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready_o;
  logic       host_clk;
  logic       ps2_clk_line;
  logic       ps2_clk_o;
  logic       ps2_dat_o;
  logic       busy_o;
  logic       done_o;
  logic       abort_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_cnt     = 0;
  int abort_cnt    = 0;
  int fall_cnt     = 0;
  int ready_lo_cnt = 0;
  logic prev_clk_o = 1'b1;

  assign ps2_clk_line = ps2_clk_o & host_clk;

  ps2_dev_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_HP     (GAP_HP),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready_o),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_dat_o  (ps2_dat_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .abort_o    (abort_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (abort_o) abort_cnt <= abort_cnt + 1;
    if (!tx_ready_o) ready_lo_cnt <= ready_lo_cnt + 1;
    if (prev_clk_o && !ps2_clk_o) fall_cnt <= fall_cnt + 1;
    prev_clk_o <= ps2_clk_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected frame, bit 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return {1'b1, p, d, 1'b0};
  endfunction

  // Move to just after the falling edge: sample outputs, drive inputs.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output int t);
    tx_data  = d;
    tx_valid = 1'b1;
    t        = cyc;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic get_frame(output logic [10:0] bits, output int t_start, output bit ok);
    int   guard;
    int   n;
    logic prev;
    guard = 0;
    n     = 0;
    bits  = '0;
    while (!(ps2_clk_o && !ps2_dat_o) && guard < 1000) begin
      step();
      guard++;
    end
    t_start = cyc;
    prev    = 1'b1;
    while (n < 11 && guard < 1000) begin
      if (prev && !ps2_clk_o) begin
        bits[n] = ps2_dat_o;
        n++;
      end
      prev = ps2_clk_o;
      step();
      guard++;
    end
    ok = (n == 11);
  endtask

  task automatic wait_done(output int t, output bit ok);
    int guard;
    guard = 0;
    while (!done_o && guard < 500) begin
      step();
      guard++;
    end
    t  = cyc;
    ok = done_o;
  endtask

  task automatic wait_idle(output int t, output bit ok);
    int guard;
    guard = 0;
    while (busy_o && guard < 2000) begin
      step();
      guard++;
    end
    t  = cyc;
    ok = !busy_o;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    host_clk = 1'b1;
    repeat (3) step();
    tests_run++;
    if (ps2_clk_o !== 1'b1) begin tests_failed++; $display("FAIL reset_clk_o: got %b want 1", ps2_clk_o); end
    tests_run++;
    if (ps2_dat_o !== 1'b1) begin tests_failed++; $display("FAIL reset_dat_o: got %b want 1", ps2_dat_o); end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests_run++;
    if (done_o !== 1'b0 || abort_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got done=%b abort=%b want 0/0", done_o, abort_o);
    end
    tests_run++;
    if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", tx_ready_o); end
    rst = 1'b0;
    repeat (4) step();
    tests_run++;
    if (busy_o !== 1'b0 || ps2_clk_o !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_idle: got busy=%b clk=%b want 0/1", busy_o, ps2_clk_o);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_single();
    int t_push, t_s, t_d, t_i, d0;
    logic [10:0] f;
    bit ok;
    d0 = done_cnt;
    push(8'h1C, t_push);
    get_frame(f, t_s, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_frame_timeout: got no frame want 11 bits"); end
    tests_run++;
    if (f !== 11'h438) begin tests_failed++; $display("FAIL single_bits: got %03h want 438", f); end
    tests_run++;
    if (t_s - t_push != 2) begin tests_failed++; $display("FAIL start_latency: got %0d want 2", t_s - t_push); end
    wait_done(t_d, ok);
    tests_run++;
    if (!ok || t_d - t_s != 88) begin
      tests_failed++; $display("FAIL done_timing: got %0d want 88", t_d - t_s);
    end
    step();
    tests_run++;
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL done_width: got %b want 0", done_o); end
    wait_idle(t_i, ok);
    tests_run++;
    if (!ok || t_i - t_d != 16) begin
      tests_failed++; $display("FAIL busy_drop: got %0d want 16", t_i - t_d);
    end
    step();
    tests_run++;
    if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    $display("[TB] single 0x1C: frame=%03h start_lat=%0d done_lat=%0d", f, t_s - t_push, t_d - t_s);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t_s1, t_s2, t_d1, t_d2, t_i, r0;
    logic [10:0] f1, f2;
    bit ok1, ok2, okd;
    r0 = ready_lo_cnt;
    push(8'h00, t0);
    push(8'hF0, t1);
    get_frame(f1, t_s1, ok1);
    wait_done(t_d1, okd);
    get_frame(f2, t_s2, ok2);
    tests_run++;
    if (!ok1 || !ok2 || !okd) begin
      tests_failed++; $display("FAIL b2b_timeout: got ok=%b%b%b want 111", ok1, okd, ok2);
    end
    tests_run++;
    if (f1 !== 11'h600) begin tests_failed++; $display("FAIL b2b_frame0: got %03h want 600", f1); end
    tests_run++;
    if (f2 !== 11'h7E0) begin tests_failed++; $display("FAIL b2b_frame1: got %03h want 7e0", f2); end
    tests_run++;
    if (f1[9] !== 1'b1 || f2[9] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_parity: got %b%b want 11", f1[9], f2[9]);
    end
    tests_run++;
    if (t_s2 - t_d1 - 1 != 16) begin
      tests_failed++; $display("FAIL b2b_gap: got %0d want 16", t_s2 - t_d1 - 1);
    end
    wait_done(t_d2, okd);
    wait_idle(t_i, ok1);
    tests_run++;
    if (ready_lo_cnt != r0) begin
      tests_failed++; $display("FAIL b2b_ready: got %0d low cycles want 0", ready_lo_cnt - r0);
    end
    $display("[TB] back-to-back 0x00,0xF0: frames=%03h,%03h gap=%0d", f1, f2, t_s2 - t_d1 - 1);
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes_q [4];
    logic [10:0] f;
    int t, t_s, f0, d0;
    bit ok;
    bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33; bytes_q[3] = 8'h44;
    host_clk = 1'b0;
    repeat (4) step();
    d0 = done_cnt;
    f0 = fall_cnt;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready_before_%0d: got %b want 1", i, tx_ready_o); end
      push(bytes_q[i], t);
    end
    tests_run++;
    if (tx_ready_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_full: got %b want 0", tx_ready_o); end
    push(8'h55, t);
    repeat (40) step();
    tests_run++;
    if (fall_cnt != f0) begin tests_failed++; $display("FAIL ovf_no_toggle: got %0d falls want 0", fall_cnt - f0); end
    tests_run++;
    if (tx_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_held: got ready=%b busy=%b want 0/1", tx_ready_o, busy_o);
    end
    host_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_frame(f, t_s, ok);
      tests_run++;
      if (!ok || f !== exp_frame(bytes_q[i])) begin
        tests_failed++; $display("FAIL ovf_frame_%0d: got %03h want %03h", i, f, exp_frame(bytes_q[i]));
      end
      $display("[TB] overflow frame %0d: got %03h", i, f);
    end
    wait_idle(t, ok);
    step();
    tests_run++;
    if (!ok || done_cnt - d0 != 4) begin
      tests_failed++; $display("FAIL ovf_done_count: got %0d want 4", done_cnt - d0);
    end
  endtask

  task automatic test_inhibit();
    int t, t_s, t_a, t_d, d0, a0, guard;
    logic [10:0] f;
    bit ok;
    d0 = done_cnt;
    a0 = abort_cnt;
    push(8'hAA, t);
    guard = 0;
    while (!(ps2_clk_o && !ps2_dat_o) && guard < 100) begin step(); guard++; end
    t_s = cyc;
    // Data bit 5 is frame bit 6; its released half starts 48 cycles in.
    while (cyc < t_s + 48) step();
    host_clk = 1'b0;
    guard = 0;
    while (!abort_o && guard < 40) begin step(); guard++; end
    t_a = cyc;
    tests_run++;
    if (!abort_o || t_a - t_s != 52) begin
      tests_failed++; $display("FAIL abort_timing: got %0d want 52", t_a - t_s);
    end
    tests_run++;
    if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1) begin
      tests_failed++; $display("FAIL abort_release: got clk=%b dat=%b want 1/1", ps2_clk_o, ps2_dat_o);
    end
    step();
    tests_run++;
    if (abort_o !== 1'b0) begin tests_failed++; $display("FAIL abort_width: got %b want 0", abort_o); end
    repeat (25) step();
    tests_run++;
    if (busy_o !== 1'b1 || ps2_clk_o !== 1'b1 || done_cnt != d0) begin
      tests_failed++; $display("FAIL inhibit_hold: got busy=%b clk=%b dones=%0d want 1/1/0", busy_o, ps2_clk_o, done_cnt - d0);
    end
    host_clk = 1'b1;
    get_frame(f, t_s, ok);
    tests_run++;
    if (!ok || f !== 11'h754) begin tests_failed++; $display("FAIL resend_frame: got %03h want 754", f); end
    wait_done(t_d, ok);
    wait_idle(t, ok);
    step();
    tests_run++;
    if (done_cnt - d0 != 1 || abort_cnt - a0 != 1) begin
      tests_failed++; $display("FAIL inhibit_counts: got done=%0d abort=%0d want 1/1", done_cnt - d0, abort_cnt - a0);
    end
    $display("[TB] inhibit 0xAA: abort at +%0d, resent frame=%03h", t_a - t_s, f);
  endtask

  task automatic test_reset_mid();
    int t, t_s, t_d, d0, guard;
    logic [10:0] f;
    bit ok;
    push(8'h5A, t);
    guard = 0;
    while (!(ps2_clk_o && !ps2_dat_o) && guard < 100) begin step(); guard++; end
    t_s = cyc;
    while (cyc < t_s + 28) step();
    tests_run++;
    if (ps2_clk_o !== 1'b0) begin tests_failed++; $display("FAIL mid_bit3_low: got %b want 0", ps2_clk_o); end
    d0  = done_cnt;
    rst = 1'b1;
    step();
    tests_run++;
    if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1 || tx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_release: got clk=%b dat=%b ready=%b busy=%b want 1/1/1/0",
               ps2_clk_o, ps2_dat_o, tx_ready_o, busy_o);
    end
    rst = 1'b0;
    repeat (150) step();
    tests_run++;
    if (done_cnt != d0) begin tests_failed++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
    push(8'h3C, t);
    get_frame(f, t_s, ok);
    tests_run++;
    if (!ok || f !== exp_frame(8'h3C)) begin
      tests_failed++; $display("FAIL post_reset_frame: got %03h want %03h", f, exp_frame(8'h3C));
    end
    wait_done(t_d, ok);
    tests_run++;
    if (!ok || t_d - t_s != 88) begin
      tests_failed++; $display("FAIL post_reset_done: got %0d want 88", t_d - t_s);
    end
    wait_idle(t, ok);
    $display("[TB] reset mid-frame: new frame=%03h", f);
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    host_clk = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_inhibit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_dev_tx.md
PS2_DEV_TX -- requirements
Module: ps2_dev_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2500: clk_i cycles per PS/2 clock half-period (10 kHz at 50 MHz).
REQ-002 The block SHALL have parameter GAP_HP, default 4: idle half-periods after every frame or abort.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two: number of queued bytes.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_i  in  1  system clock; all logic rises on this edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 tx_data_i  in  8  scancode byte to send.
REQ-008 tx_valid_i  in  1  push request; a byte is accepted when tx_valid_i and tx_ready_o are both high.
REQ-009 tx_ready_o  out  1  FIFO not full.
REQ-010 ps2_clk_i  in  1  sensed PS/2 clock line; the host may hold it low to inhibit.
REQ-011 ps2_clk_o  out  1  clock drive; 0 pulls the line low, 1 releases it (open-drain).
REQ-012 ps2_dat_o  out  1  data drive; 0 pulls the line low, 1 releases it (open-drain).
REQ-013 busy_o  out  1  high when the FSM is not IDLE or the FIFO is not empty.
REQ-014 done_o  out  1  one-cycle pulse when a frame completes.
REQ-015 abort_o  out  1  one-cycle pulse when a frame is aborted by host inhibit.

Function
REQ-016 Frame: 11 bits, start=0, data[0..7] LSB first, odd parity, stop=1.
- Odd parity: the total count of ones in data plus parity is odd.
REQ-017 Each bit SHALL occupy two half-periods.
- HI: ps2_clk_o=1; ps2_dat_o updates on the first cycle of HI.
- LO: ps2_clk_o=0; ps2_dat_o holds.
REQ-018 ps2_clk_i SHALL pass through a 2-FF synchronizer (clk_s) before any use.
REQ-019 FSM states SHALL be IDLE, SEND_HI, SEND_LO and GAP.
REQ-020 IDLE->SEND_HI when the FIFO is not empty and clk_s=1; IDLE holds while clk_s=0.
REQ-021 SEND_HI->SEND_LO after CLK_DIV cycles.
REQ-022 On the last SEND_HI cycle, if clk_s=0 (host inhibit), the FSM SHALL abort:
- pulse abort_o;
- release both lines the next cycle;
- go to GAP;
- leave the FIFO head unpopped, so the same byte is retransmitted in full.
REQ-023 SEND_LO->SEND_HI after CLK_DIV cycles for bits 0..9.
REQ-024 After the stop bit's SEND_LO, the FSM SHALL pop the FIFO, pulse done_o and go to GAP.
REQ-025 GAP->IDLE after GAP_HP*CLK_DIV cycles; both lines stay released throughout GAP.
REQ-026 The start bit SHALL appear on ps2_dat_o two cycles after a push into an empty FIFO, given an idle FSM and clk_s=1.
REQ-027 The head byte and its parity SHALL be latched into a shift register when SEND_HI is entered from IDLE.
REQ-028 tx_ready_o = !full.
- A push and a pop in the same cycle SHALL both take effect.
- A push while full SHALL be ignored.
REQ-029 The half-period counter width SHALL be clog2(CLK_DIV*GAP_HP+1); the bit index SHALL count 0..10 without wrap.
REQ-030 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, with full/empty taken from MSB comparison.

Reset
REQ-031 While rst_i is high at a clock edge, the block SHALL set:
- FSM to IDLE, FIFO empty;
- ps2_clk_o=1, ps2_dat_o=1;
- busy_o=0, done_o=0, abort_o=0;
- tx_ready_o=1;
- synchronizer flops to 1.
REQ-032 A reset mid-frame SHALL release both lines on that same edge and discard the partial frame; no done_o is produced for it.

Structure
REQ-033 Package ps2_dev_pkg SHALL hold:
- the FSM state encoding;
- FRAME_BITS=11;
- PS2_START=0 and PS2_STOP=1.
REQ-034 The FIFO SHALL be a separate sub-module, ps2_dev_fifo (synchronous, parameterised width and depth); the FSM, counters and synchronizer stay in ps2_dev_tx.

Verification
REQ-035 All scenarios run with CLK_DIV=4, GAP_HP=4 and ps2_clk_i modelled as wired-AND.
REQ-036 Push 0x1C:
- ps2_dat_o sampled at each ps2_clk_o fall = 0,0,0,1,1,1,0,0,0,0,1 (start, data, parity=0, stop);
- done_o pulses 88 cycles after the start bit;
- busy_o drops 16 cycles later.
REQ-037 Push 0x00 then 0xF0 back-to-back:
- both frames have parity 1;
- the gap between frames is exactly 16 released cycles;
- tx_ready_o stays 1.
REQ-038 Push 5 bytes with FIFO_DEPTH=4 while ps2_clk_i is held low:
- tx_ready_o=0 after the 4th push and the 5th is dropped;
- no ps2_clk_o toggles occur;
- on release, 4 frames are sent in order.
REQ-039 Inhibit: host pulls the clock low during bit 5's HI phase of 0xAA:
- abort_o pulses and both lines release;
- after GAP and host release, 0xAA is resent in full and done_o pulses once.
REQ-040 Assert rst_i during bit 3 of a frame:
- next cycle ps2_clk_o=ps2_dat_o=1 and tx_ready_o=1;
- no done_o pulse occurs;
- a new push after reset transmits correctly.
